// File: rtl/uart_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_status_tx
// Purpose  : Formats the RGB LED state as the 7-byte ASCII message
//            "L=RGB\r\n" and writes it byte-by-byte into the simpleuart
//            data-register write port. A message is queued by an explicit
//            request, by an LED-state change (AUTO_REPORT) and by a periodic
//            heartbeat (HEARTBEAT_CYCLES).
// Ports    : hw_clk       - system clock (12 MHz)
//            reset        - asynchronous active-high reset
//            rgb_state    - {red, green, blue} LED state
//            report_req   - single-cycle report request
//            reg_dat_we   - simpleuart data write strobe
//            reg_dat_di   - simpleuart write data (bits 31:8 always 0)
//            reg_dat_wait - simpleuart stall
//            busy         - message in progress
//            tx_done      - one-cycle pulse after the last byte is accepted
// Revision : 1.0 - initial release
// ============================================================================
module uart_status_tx #(
  parameter int          AUTO_REPORT      = 1,
  parameter int unsigned HEARTBEAT_CYCLES = 32'd12000000
) (
  input  logic        hw_clk,
  input  logic        reset,
  input  logic [2:0]  rgb_state,
  input  logic        report_req,
  output logic        reg_dat_we,
  output logic [31:0] reg_dat_di,
  input  logic        reg_dat_wait,
  output logic        busy,
  output logic        tx_done
);

  localparam logic [0:0]  S_IDLE    = 1'b0;
  localparam logic [0:0]  S_SEND    = 1'b1;
  localparam logic [2:0]  c_IDX_LAST = 3'd6;
  localparam logic        c_AUTO    = (AUTO_REPORT != 0);
  localparam logic        c_HB_EN   = (HEARTBEAT_CYCLES != 0);
  localparam logic [31:0] c_HB_LAST = c_HB_EN ? (HEARTBEAT_CYCLES - 32'd1) : 32'd0;

  logic [0:0]  r_state;
  logic        r_pending;
  logic [2:0]  r_idx;
  logic [2:0]  r_snap;
  logic [2:0]  r_last_rep;
  logic [31:0] r_hb_cnt;
  logic        r_tx_done;

  logic        w_accept;
  logic        w_capture;
  logic        w_hb_hit;
  logic        w_led_change;
  logic        w_set;
  logic [7:0]  w_byte;

  assign w_accept  = (r_state == S_SEND) && !reg_dat_wait;
  assign w_capture = (r_state == S_IDLE) && r_pending;
  assign w_hb_hit  = c_HB_EN && (r_hb_cnt == c_HB_LAST);

  // On the capture cycle last_rep is being loaded with rgb_state itself, so
  // comparing against the old value would queue a spurious duplicate report.
  assign w_led_change = c_AUTO && !w_capture && (rgb_state != r_last_rep);
  assign w_set        = report_req || w_led_change || w_hb_hit;

  // Message byte selected by the current index; LED digits are '0'/'1'.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0:    w_byte = 8'h4C;
      3'd1:    w_byte = 8'h3D;
      3'd2:    w_byte = {7'b0011000, r_snap[2]};
      3'd3:    w_byte = {7'b0011000, r_snap[1]};
      3'd4:    w_byte = {7'b0011000, r_snap[0]};
      3'd5:    w_byte = 8'h0D;
      3'd6:    w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  // Outputs decode straight from registered state, so reset removes the
  // write strobe asynchronously and the data is stable across stalls.
  assign busy       = (r_state == S_SEND);
  assign reg_dat_we = busy;
  assign reg_dat_di = busy ? {24'b0, w_byte} : 32'b0;
  assign tx_done    = r_tx_done;

  // Free-running heartbeat counter, held at zero when disabled.
  always_ff @(posedge hw_clk or posedge reset) begin
    if (reset) begin
      r_hb_cnt <= 32'd0;
    end else if (!c_HB_EN || w_hb_hit) begin
      r_hb_cnt <= 32'd0;
    end else begin
      r_hb_cnt <= r_hb_cnt + 32'd1;
    end
  end

  always_ff @(posedge hw_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pending  <= 1'b0;
      r_idx      <= 3'd0;
      r_snap     <= 3'd0;
      r_last_rep <= 3'd0;
      r_tx_done  <= 1'b0;
    end else begin
      // One-deep request flag; a new request wins over the capture clear.
      r_pending <= w_set || (r_pending && !w_capture);
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_snap     <= rgb_state;
            r_last_rep <= rgb_state;
            r_idx      <= 3'd0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (r_idx == c_IDX_LAST) begin
              r_idx     <= 3'd0;
              r_state   <= S_IDLE;
              r_tx_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_status_tx
// Purpose  : Self-checking bench for uart_status_tx. A message-level model
//            predicts every byte sequence; directed scenarios cover latency,
//            stalling sink, LED changes, collapsing requests, reset abort and
//            heartbeat period, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_status_tx;

  logic        hw_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [2:0]  rgb_state = 3'b000;
  logic        report_req = 1'b0;
  logic        reg_dat_wait = 1'b0;
  logic        reg_dat_we;
  logic [31:0] reg_dat_di;
  logic        busy;
  logic        tx_done;

  // Heartbeat-only instance
  logic [2:0]  h_rgb  = 3'b011;
  logic        h_req  = 1'b0;
  logic        h_wait = 1'b0;
  logic        h_we;
  logic [31:0] h_di;
  logic        h_busy;
  logic        h_done;

  uart_status_tx #(.AUTO_REPORT(1), .HEARTBEAT_CYCLES(0)) dut (
    .hw_clk(hw_clk), .reset(reset), .rgb_state(rgb_state), .report_req(report_req),
    .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_wait(reg_dat_wait),
    .busy(busy), .tx_done(tx_done)
  );

  uart_status_tx #(.AUTO_REPORT(0), .HEARTBEAT_CYCLES(100)) dut_hb (
    .hw_clk(hw_clk), .reset(reset), .rgb_state(h_rgb), .report_req(h_req),
    .reg_dat_we(h_we), .reg_dat_di(h_di), .reg_dat_wait(h_wait),
    .busy(h_busy), .tx_done(h_done)
  );

  always #5 hw_clk = ~hw_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Message-level reference: an outstanding-request flag, a transmitter
  // busy flag with bytes-remaining count, and the queue of expected bytes.
  bit          m_pend, m_send, m_done_exp;
  int          m_left;
  logic [2:0]  m_last;
  logic [7:0]  q[$];

  // Monitor / sink state
  int          cyc = 0, msgs_done = 0, we_rise_cyc = 0, done_cyc = 0;
  int          n_rises = 0, cur_acc = 0, sink_mode = 0, stall = 0;
  int          h_prev_rise = -1, h_rises = 0;
  bit          prev_we, prev_wait, h_prev_busy;
  logic [31:0] prev_di;

  task automatic model_reset();
    m_pend = 0; m_send = 0; m_done_exp = 0; m_left = 0; m_last = 3'b000;
    q.delete();
    prev_we = 0; prev_wait = 0; prev_di = 0; stall = 0; cur_acc = 0;
    h_prev_rise = -1; h_prev_busy = 0;
  endtask

  task automatic push_msg(input logic [2:0] v);
    q.push_back("L");
    q.push_back("=");
    q.push_back(v[2] ? "1" : "0");
    q.push_back(v[1] ? "1" : "0");
    q.push_back(v[0] ? "1" : "0");
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  // One clock cycle: drive inputs just after the falling edge, check the
  // outputs for this cycle, then advance the model across the rising edge.
  task automatic tick(input bit req, input logic [2:0] rgb);
    bit          acc, start, diff;
    logic [7:0]  exp_b;
    report_req = req;
    rgb_state  = rgb;
    case (sink_mode)
      0:       reg_dat_wait = 1'b0;
      1:       reg_dat_wait = (stall > 0);
      default: reg_dat_wait = ($urandom_range(0, 2) == 0);
    endcase
    #1;
    chk("busy", busy, m_send);
    chk("we", reg_dat_we, m_send);
    if (tx_done || m_done_exp) chk("tx_done", tx_done, m_done_exp);
    if (prev_we && prev_wait) chk("di_stable", reg_dat_di, prev_di);
    if (!reg_dat_we) chk("di_idle", reg_dat_di, 32'd0);
    if (reg_dat_we && !prev_we) begin
      we_rise_cyc = cyc;
      n_rises++;
    end
    if (tx_done) begin
      done_cyc = cyc;
      msgs_done++;
      cur_acc = 0;
    end
    acc = reg_dat_we && !reg_dat_wait;
    if (acc) begin
      chk("byte_expected", (q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_b = q.pop_front();
        chk("byte", reg_dat_di, {24'b0, exp_b});
      end
      cur_acc++;
    end
    if (h_busy && !h_prev_busy) begin
      if (h_prev_rise >= 0) chk("hb_period", cyc - h_prev_rise, 100);
      h_prev_rise = cyc;
      h_rises++;
    end
    h_prev_busy = h_busy;

    start = !m_send && m_pend;
    diff  = (rgb != m_last) && !start;
    m_done_exp = 0;
    if (start) begin
      push_msg(rgb);
      m_last = rgb;
      m_send = 1;
      m_left = 7;
    end else if (m_send && !reg_dat_wait) begin
      m_left--;
      if (m_left == 0) begin
        m_send = 0;
        m_done_exp = 1;
      end
    end
    m_pend = (m_pend && !start) || req || diff;

    if (acc) stall = 1250;
    else if (stall > 0) stall--;
    prev_we = reg_dat_we; prev_wait = reg_dat_wait; prev_di = reg_dat_di;
    cyc++;
    @(negedge hw_clk);
  endtask

  task automatic idle(input int n, input logic [2:0] rgb);
    for (int i = 0; i < n; i++) tick(1'b0, rgb);
  endtask

  initial begin
    int c0, base, d, hb_base;
    logic [2:0] cur;
    model_reset();
    rgb_state = 3'b101;
    repeat (3) @(negedge hw_clk);
    chk("rst_we", reg_dat_we, 0);
    chk("rst_di", reg_dat_di, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_hb_we", h_we, 0);
    reset = 1'b0;

    // Non-zero LED state after release queues a report immediately
    idle(15, 3'b101);
    chk("auto_after_reset", msgs_done, 1);

    // Request latency with a zero-wait sink
    c0 = cyc;
    tick(1'b1, 3'b101);
    idle(12, 3'b101);
    chk("lat_we", we_rise_cyc - c0, 2);
    chk("lat_done", done_cyc - c0, 9);
    chk("we_run_len", done_cyc - we_rise_cyc, 7);
    chk("req_msgs", msgs_done, 2);

    // Stalling sink: 1250 wait cycles after each accepted byte
    sink_mode = 1;
    tick(1'b1, 3'b101);
    for (int i = 0; i < 10000 && msgs_done < 3; i++) tick(1'b0, 3'b101);
    sink_mode = 0;
    stall = 0;
    d = done_cyc - we_rise_cyc;
    chk("stall_msgs", msgs_done, 3);
    chk("stall_len", (d >= 6 * 1250) && (d <= 7 * 1252), 1);
    idle(5, 3'b101);

    // LED change while idle, then a toggle during the message
    idle(15, 3'b000);
    base = msgs_done;
    idle(3, 3'b010);
    tick(1'b0, 3'b100);
    idle(25, 3'b010);
    chk("led_toggle_msgs", msgs_done - base, 2);

    // Request and LED change together: idle, then during a message
    base = msgs_done;
    tick(1'b1, 3'b110);
    idle(20, 3'b110);
    chk("req_led_idle_msgs", msgs_done - base, 1);
    base = msgs_done;
    tick(1'b1, 3'b110);
    idle(2, 3'b110);
    tick(1'b1, 3'b001);
    idle(25, 3'b001);
    chk("req_led_send_msgs", msgs_done - base, 2);

    // Reset while byte 3 is stalled
    sink_mode = 1;
    tick(1'b1, 3'b001);
    for (int i = 0; i < 6000 && cur_acc < 3; i++) tick(1'b0, 3'b001);
    idle(3, 3'b001);
    reset = 1'b1;
    #1;
    chk("abort_we", reg_dat_we, 0);
    chk("abort_busy", busy, 0);
    rgb_state = 3'b000;
    @(posedge hw_clk);
    @(negedge hw_clk);
    reset = 1'b0;
    model_reset();
    sink_mode = 0;
    base = n_rises;
    idle(200, 3'b000);
    chk("no_msg_after_reset", n_rises - base, 0);

    // Randomized traffic with a random-stall sink
    sink_mode = 2;
    cur = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) cur = 3'($urandom_range(0, 7));
      tick($urandom_range(0, 24) == 0, cur);
    end
    sink_mode = 0;
    idle(40, cur);
    chk("queue_drained", q.size(), 0);

    // No stimulus for 10000 cycles: heartbeat disabled on the main instance
    base = n_rises;
    hb_base = h_rises;
    idle(10000, cur);
    chk("hb0_quiet", n_rises - base, 0);
    chk("hb100_count", (h_rises - hb_base >= 99) && (h_rises - hb_base <= 101), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
